// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared states and segment constants; SEVEN_SEG_ACTIVE_LOW_EN selects active-low segment outputs
package seven_seg_pkg;

    localparam int SEG_WIDTH    = 7;
    localparam int NIBBLE_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LO_WAIT = 3'd1,
        LO_CAP  = 3'd2,
        HI_WAIT = 3'd3,
        HI_CAP  = 3'd4
    } seq_state_e;

`ifdef SEVEN_SEG_ACTIVE_LOW_EN
    localparam logic [SEG_WIDTH-1:0] SEG_BLANK = 7'h7F;
`else
    localparam logic [SEG_WIDTH-1:0] SEG_BLANK = 7'h00;
`endif

    // Polarity is applied as the pattern is captured, so outputs stay registered
    function automatic logic [SEG_WIDTH-1:0] seg_drive(input logic [SEG_WIDTH-1:0] pattern);
`ifdef SEVEN_SEG_ACTIVE_LOW_EN
        return ~pattern;
`else
        return pattern;
`endif
    endfunction

endpackage

// File: rtl/seven_seg_refresh_tick.sv
// rtl/seven_seg_refresh_tick.sv - free-running 0..CLKS_PER_REFRESH-1 counter with a one-cycle tick on wrap
module seven_seg_refresh_tick #(
    parameter int CLKS_PER_REFRESH = 25000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    output logic o_Tick
);

    localparam int              CNT_W   = $clog2(CLKS_PER_REFRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_REFRESH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick is high during the last count so the wrap edge itself raises the request
    always_comb begin
        o_Tick = (cnt_q == CNT_MAX);
        cnt_d  = o_Tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seven_seg_update_ctrl.sv
// rtl/seven_seg_update_ctrl.sv - time-shares one registered hex decoder across two digits; SEVEN_SEG_ACTIVE_LOW_EN inverts captured segments
module seven_seg_update_ctrl
    import seven_seg_pkg::*;
#(
    parameter int CLKS_PER_REFRESH = 25000
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Value_Valid,
    input  logic [7:0]              i_Value,
    output logic                    o_Value_Ready,
    output logic [NIBBLE_WIDTH-1:0] o_Dec_Binary,
    input  logic [SEG_WIDTH-1:0]    i_Dec_Segments,
    output logic [SEG_WIDTH-1:0]    o_Digit1_Seg,
    output logic [SEG_WIDTH-1:0]    o_Digit2_Seg,
    output logic                    o_Update_Done
);

    seq_state_e              state_q, state_d;
    logic [7:0]              held_q, held_d;
    logic [NIBBLE_WIDTH-1:0] dec_bin_q, dec_bin_d;
    logic [SEG_WIDTH-1:0]    dig1_q, dig1_d;
    logic [SEG_WIDTH-1:0]    dig2_q, dig2_d;
    logic                    done_q, done_d;
    logic                    pend_q, pend_d;
    logic                    seq_start;
    logic                    refresh_tick;

    seven_seg_refresh_tick #(
        .CLKS_PER_REFRESH(CLKS_PER_REFRESH)
    ) u_refresh_tick (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .o_Tick (refresh_tick)
    );

    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        dec_bin_d = dec_bin_q;
        dig1_d    = dig1_q;
        dig2_d    = dig2_q;
        done_d    = 1'b0;
        seq_start = 1'b0;

        case (state_q)
            IDLE: begin
                // A new value also covers any outstanding refresh request
                if (i_Value_Valid) begin
                    held_d    = i_Value;
                    dec_bin_d = i_Value[3:0];
                    seq_start = 1'b1;
                    state_d   = LO_WAIT;
                end else if (pend_q) begin
                    dec_bin_d = held_q[3:0];
                    seq_start = 1'b1;
                    state_d   = LO_WAIT;
                end
            end
            LO_WAIT: state_d = LO_CAP;
            LO_CAP: begin
                dig2_d    = seg_drive(i_Dec_Segments);
                dec_bin_d = held_q[7:4];
                state_d   = HI_WAIT;
            end
            HI_WAIT: state_d = HI_CAP;
            HI_CAP: begin
                dig1_d  = seg_drive(i_Dec_Segments);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Wraps while busy collapse into one request; a starting sequence satisfies it
        if (seq_start) begin
            pend_d = 1'b0;
        end else if (refresh_tick) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= IDLE;
            held_q    <= 8'h00;
            dec_bin_q <= '0;
            dig1_q    <= SEG_BLANK;
            dig2_q    <= SEG_BLANK;
            done_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            held_q    <= held_d;
            dec_bin_q <= dec_bin_d;
            dig1_q    <= dig1_d;
            dig2_q    <= dig2_d;
            done_q    <= done_d;
            pend_q    <= pend_d;
        end
    end

    assign o_Value_Ready = (state_q == IDLE);
    assign o_Dec_Binary  = dec_bin_q;
    assign o_Digit1_Seg  = dig1_q;
    assign o_Digit2_Seg  = dig2_q;
    assign o_Update_Done = done_q;

endmodule
